// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, legal access sizes and default capacity
package dmem_pkg;
  localparam int DMEM_DEPTH = 1024;
  localparam logic [3:0] XFER_1 = 4'd1;
  localparam logic [3:0] XFER_2 = 4'd2;
  localparam logic [3:0] XFER_4 = 4'd4;
  localparam logic [3:0] XFER_8 = 4'd8;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: byte-wide single-port storage, synchronous write, combinational read
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-serial big-endian load/store responder over a byte RAM
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        resp_valid,
  output logic [63:0] read_data,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [AW-1:0] addr_q;
  logic [3:0] size_q, cnt;
  logic we_q, size_ok, misalign, over, err, last;
  logic [63:0] sr;
  logic [7:0] rbyte;
  assign size_ok = xfer_size == XFER_1 || xfer_size == XFER_2 || xfer_size == XFER_4 || xfer_size == XFER_8;
  assign misalign = |(address[3:0] & (xfer_size - 4'd1));
  assign over = {1'b0, address} + 65'(xfer_size) > 65'(DEPTH);
  assign err = (write_enable == read_enable) || !size_ok || misalign || over;
  assign last = cnt == size_q - 4'd1;
  // Stores shift the value out MSB-first; loads shift bytes in at the bottom.
  dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (state == ACCESS && we_q && !reset),
    .addr (addr_q + AW'(cnt)),
    .wdata(sr[63:56]),
    .rdata(rbyte)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q    <= address[AW-1:0];
          size_q    <= xfer_size;
          we_q      <= write_enable;
          sr        <= write_enable ? write_data << {4'd8 - xfer_size, 3'b000} : '0;
          cnt       <= '0;
          req_ready <= 1'b0;
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            read_data  <= '0;
            resp_err   <= 1'b1;
          end else state <= ACCESS;
        end
        ACCESS: begin
          sr  <= we_q ? sr << 8 : {sr[55:0], rbyte};
          cnt <= cnt + 4'd1;
          if (last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            read_data  <= we_q ? '0 : {sr[55:0], rbyte};
            resp_err   <= 1'b0;
            cnt        <= '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store, error, reset-abort and back-to-back checks
module tb_dmem_responder;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, write_enable = 1'b0, read_enable = 1'b0;
  logic req_ready, resp_valid, resp_err;
  logic [63:0] address = '0, write_data = '0, read_data;
  logic [3:0] xfer_size = 4'd1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dmem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .xfer_size(xfer_size), .resp_valid(resp_valid),
    .read_data(read_data), .resp_err(resp_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d, input logic [3:0] n);
    req_valid = 1'b1; write_enable = w; read_enable = r; address = a; write_data = d; xfer_size = n;
  endtask
  // Issue one request and return the response plus edges from accept to resp_valid.
  task automatic xfer(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                      input logic [3:0] n, output logic [63:0] rd, output logic e, output int lat);
    int g;
    @(negedge clk);
    drive(w, r, a, d, n);
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    rd = read_data; e = resp_err;
  endtask
  task automatic access(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [3:0] n, input logic [63:0] exp_rd, input int exp_lat);
    logic [63:0] rd; logic e; int lat;
    xfer(w, !w, a, d, n, rd, e, lat);
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_err"}, 64'(e), 64'd0);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask
  task automatic reject(input string tag, input logic w, input logic r, input logic [63:0] a, input logic [3:0] n);
    logic [63:0] rd; logic e; int lat;
    xfer(w, r, a, 64'hDEAD_BEEF_DEAD_BEEF, n, rd, e, lat);
    check({tag, "_data"}, rd, 64'd0);
    check({tag, "_err"}, 64'(e), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd1);
  endtask
  initial begin
    int seen, bad_ready, lat;
    logic [63:0] rd;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_data", read_data, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    access("st8", 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 4'd8, 64'd0, 9);
    access("ld8", 1'b0, 64'h10, 64'd0, 4'd8, 64'h0123_4567_89AB_CDEF, 9);
    access("ld1", 1'b0, 64'h10, 64'd0, 4'd1, 64'h01, 2);
    access("ld2", 1'b0, 64'h16, 64'd0, 4'd2, 64'hCDEF, 3);
    access("ld4", 1'b0, 64'h14, 64'd0, 4'd4, 64'h89AB_CDEF, 5);
    reject("mis4", 1'b0, 1'b1, 64'h12, 4'd4);
    reject("both", 1'b1, 1'b1, 64'h10, 4'd8);
    reject("none", 1'b0, 1'b0, 64'h10, 4'd8);
    reject("sz3", 1'b1, 1'b0, 64'h10, 4'd3);
    reject("oob", 1'b1, 1'b0, 64'd1024, 4'd8);
    reject("wrap", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 4'd8);
    repeat (3) @(negedge clk);
    check("hold_data", read_data, 64'd0);
    check("hold_err", 64'(resp_err), 64'd1);
    access("ld8_keep", 1'b0, 64'h10, 64'd0, 4'd8, 64'h0123_4567_89AB_CDEF, 9);
    access("st_top", 1'b1, 64'd1016, 64'hA5A5_0102_0304_5A5A, 4'd8, 64'd0, 9);
    access("ld_top", 1'b0, 64'd1022, 64'd0, 4'd2, 64'h5A5A, 3);
    access("st_zero", 1'b1, 64'h20, 64'd0, 4'd8, 64'd0, 9);
    // Abort a store after three bytes have been written.
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (resp_valid) seen++; end
    check("abort_noresp", 64'(seen), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    access("abort_ld", 1'b0, 64'h20, 64'd0, 4'd8, 64'hFFFF_FF00_0000_0000, 9);
    // Back-to-back: req_valid stays high across two requests.
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h30, 64'hBEEF, 4'd2);
    @(posedge clk); #1 drive(1'b0, 1'b1, 64'h30, 64'd0, 4'd2);
    bad_ready = 0; lat = 0;
    do begin
      @(negedge clk); lat++;
      if (req_ready) bad_ready++;
    end while (!resp_valid && lat < 50);
    check("b2b_lat1", 64'(lat), 64'd3);
    check("b2b_busy", 64'(bad_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    rd = read_data;
    check("b2b_lat2", 64'(lat), 64'd3);
    check("b2b_data", rd, 64'hBEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: DEPTH, 1024, byte capacity of the memory (power of 2, at least 8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-006 SHALL have port: address  input  64  byte address of the access.
REQ-007 SHALL have port: write_enable  input  1  store request.
REQ-008 SHALL have port: read_enable  input  1  load request.
REQ-009 SHALL have port: write_data  input  64  store value, right-justified in the low n*8 bits.
REQ-010 SHALL have port: xfer_size  input  4  access size n in bytes; legal values are 1, 2, 4 and 8.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port: read_data  output  64  load result, zero-extended.
REQ-013 SHALL have port: resp_err  output  1  request rejected, qualified by resp_valid.

Function
REQ-014 SHALL implement states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request on a posedge with req_valid && req_ready, latching address, write_data, xfer_size and both enables; inputs SHALL be ignored at all other times.
REQ-016 SHALL flag a request as an error when any of these holds: both enables are set; neither enable is set; xfer_size is not 1, 2, 4 or 8; address mod n is not 0; or address+n > DEPTH. The address+n comparison SHALL be done at 65-bit width so it cannot wrap.
REQ-017 SHALL go IDLE->RESP for an error request, with no memory access; otherwise IDLE->ACCESS.
REQ-018 SHALL, in ACCESS, transfer one byte per cycle, using byte counter i from 0 to n-1 at address+i, and SHALL go to RESP after byte n-1.
REQ-019 SHALL use big-endian ordering: the byte at address+i holds value bits [8*(n-1-i)+7 : 8*(n-1-i)].
REQ-020 SHALL, in RESP, assert resp_valid for exactly one cycle and then return to IDLE.
REQ-021 SHALL meet this latency: for an accept edge at cycle k, resp_valid is high in cycle k+n+1 for a good request and in cycle k+1 for an error request.
REQ-022 SHALL present, during the resp_valid cycle:
- for a good load: the assembled value zero-extended to 64 bits, resp_err=0;
- for a store: read_data=0, resp_err=0;
- for an error: read_data=0, resp_err=1.
REQ-023 SHALL hold read_data and resp_err stable from one response until the next response.
REQ-024 SHALL leave memory unchanged for an error request and for any load.
REQ-025 SHALL allow back-to-back requests: a req_valid held high is accepted in the cycle after RESP, giving no overlap and no gap beyond RESP.

Reset
REQ-026 SHALL, on reset, force state=IDLE, req_ready=1, resp_valid=0, read_data=0, resp_err=0 and counter=0.
REQ-027 SHALL treat reset during ACCESS as an abort: no response is issued, bytes already written stay written, and remaining bytes are not written.
REQ-028 SHALL NOT clear memory contents on reset.

Structure
REQ-029 SHALL take from shared package dmem_pkg: the state enum (IDLE, ACCESS, RESP), the legal-size constants XFER_1, XFER_2, XFER_4 and XFER_8, and the DEPTH default.
REQ-030 SHALL place storage in one sub-module, dmem_byte_ram: 8-bit wide, DEPTH entries, single port, synchronous write, combinational read.

Verification
REQ-031 SHALL cover a full-width store and load:
- stimulus: write n=8 of 0x0123456789ABCDEF at 0x10, then read n=8 at 0x10;
- response: read_data=0x0123456789ABCDEF, with resp_valid 9 cycles after each accept.
REQ-032 SHALL cover endianness after REQ-031:
- read n=1 at 0x10 -> 0x01;
- read n=2 at 0x16 -> 0xCDEF;
- read n=4 at 0x14 -> 0x89ABCDEF.
REQ-033 SHALL cover rejected requests, each giving resp_err=1 and read_data=0 one cycle after accept, with memory unchanged:
- read n=4 at 0x12 (misaligned);
- both enables set;
- xfer_size=3;
- n=8 at address 1024.
REQ-034 SHALL cover reset mid-operation:
- stimulus: write n=8 of 0 at 0x20; write n=8 of 0xFFFFFFFFFFFFFFFF at 0x20; assert reset after 3 ACCESS cycles;
- response: no resp_valid and req_ready=1 after reset; a later read n=8 at 0x20 returns 0xFFFFFF0000000000.
REQ-035 SHALL cover back-to-back requests: with req_valid held high for two requests, req_ready=0 throughout the first transaction and the second request is accepted the cycle after the first resp_valid.
